// File: rtl/regfile_write_scheduler_pkg.sv
// Write-back types shared by the register file, decode, mult/div and the write scheduler.
package regfile_write_scheduler_pkg;
    localparam int WIDTH  = 32;
    localparam int AWIDTH = 5;
    localparam logic [AWIDTH-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [AWIDTH-1:0] rd;
        logic [WIDTH-1:0]  data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_write_scheduler_wb_queue_lookup.sv
// Entry storage for the write-back queue plus two youngest-first forwarding lookups.
module wb_queue_lookup
    import regfile_write_scheduler_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        we_a_i,
    input  logic [PW-1:0]               idx_a_i,
    input  wb_entry_t                   ent_a_i,
    input  logic                        we_b_i,
    input  logic [PW-1:0]               idx_b_i,
    input  wb_entry_t                   ent_b_i,
    input  logic [PW-1:0]               head_i,
    input  logic [PW:0]                 count_i,
    output wb_entry_t                   head_ent_o,
    input  logic                        out_vld_i,
    input  wb_entry_t                   out_ent_i,
    input  logic [1:0][AWIDTH-1:0]      lk_reg_i,
    output logic [1:0]                  lk_hit_o,
    output logic [1:0][WIDTH-1:0]       lk_data_o
);
    localparam int CW = PW + 1;

    wb_entry_t mem_q [DEPTH];

    // Storage writes; the two push slots never collide because B lands after A.
    always_ff @(posedge clk_i) begin
        if (we_a_i) mem_q[idx_a_i] <= ent_a_i;
        if (we_b_i) mem_q[idx_b_i] <= ent_b_i;
    end

    assign head_ent_o = mem_q[head_i];

    for (genvar p = 0; p < 2; p++) begin : g_lk
        logic             hit;
        logic [WIDTH-1:0] data;

        // Walk oldest to youngest so later matches overwrite earlier ones; the output stage is oldest.
        always_comb begin
            hit  = 1'b0;
            data = '0;
            if (lk_reg_i[p] != REG_ZERO) begin
                if (out_vld_i && out_ent_i.rd == lk_reg_i[p]) begin
                    hit  = 1'b1;
                    data = out_ent_i.data;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) < count_i && mem_q[head_i + PW'(i)].rd == lk_reg_i[p]) begin
                        hit  = 1'b1;
                        data = mem_q[head_i + PW'(i)].data;
                    end
                end
            end
        end

        assign lk_hit_o[p]  = hit;
        assign lk_data_o[p] = data;
    end
endmodule

// File: rtl/regfile_write_scheduler.sv
// Merges pipeline and mult/div write-backs into an in-order queue and drains one write per cycle.
module regfile_write_scheduler #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 32,
    parameter int AWIDTH = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              AValid,
    input  logic [AWIDTH-1:0] AReg,
    input  logic [WIDTH-1:0]  AData,
    input  logic              BValid,
    input  logic [AWIDTH-1:0] BReg,
    input  logic [WIDTH-1:0]  BData,
    output logic              BReady,
    output logic              Stall,
    input  logic [AWIDTH-1:0] LookupReg1,
    output logic              LookupHit1,
    output logic [WIDTH-1:0]  LookupData1,
    input  logic [AWIDTH-1:0] LookupReg2,
    output logic              LookupHit2,
    output logic [WIDTH-1:0]  LookupData2,
    output logic [AWIDTH-1:0] WriteRegister,
    output logic [WIDTH-1:0]  WriteData,
    output logic              RegWrite,
    output logic              OverflowErr
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d, tail_q, tail_d, idx_b;
    logic [CW-1:0] count_q, count_d;
    logic          a_acc, b_push, b_room, pop;

    regfile_write_scheduler_pkg::wb_entry_t ent_a, ent_b, head_ent, out_ent;
    logic [1:0][AWIDTH-1:0] lk_reg;
    logic [1:0]             lk_hit;
    logic [1:0][WIDTH-1:0]  lk_data;

    // Stall leaves a slot free so a same-cycle B push always fits behind an accepted A.
    assign Stall  = count_q >= CW'(DEPTH - 1);
    assign a_acc  = AValid && !Stall && (AReg != '0);
    assign b_room = (count_q + CW'(a_acc)) < CW'(DEPTH);
    assign b_push = BValid && (BReg != '0) && b_room;
    // Register-0 writes are acknowledged immediately and simply discarded.
    assign BReady = BValid && ((BReg == '0) || b_room);
    assign pop    = count_q != '0;

    assign idx_b   = a_acc ? tail_q + PW'(1) : tail_q;
    assign tail_d  = tail_q + PW'(a_acc) + PW'(b_push);
    assign head_d  = head_q + PW'(pop);
    assign count_d = count_q + CW'(a_acc) + CW'(b_push) - CW'(pop);

    assign ent_a   = '{rd: AReg, data: AData};
    assign ent_b   = '{rd: BReg, data: BData};
    assign out_ent = '{rd: WriteRegister, data: WriteData};
    assign lk_reg  = {LookupReg2, LookupReg1};

    // Queue pointers and occupancy.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Output stage: register-file port, holds address/data when idle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else if (pop) begin
            RegWrite      <= 1'b1;
            WriteRegister <= head_ent.rd;
            WriteData     <= head_ent.data;
        end else begin
            RegWrite      <= 1'b0;
        end
    end

    // Sticky flag for a source-A request that arrived while stalled.
    always_ff @(posedge Clk) begin
        if (Reset)                OverflowErr <= 1'b0;
        else if (AValid && Stall) OverflowErr <= 1'b1;
    end

    wb_queue_lookup #(.DEPTH(DEPTH)) u_q (
        .clk_i      (Clk),
        .we_a_i     (a_acc),
        .idx_a_i    (tail_q),
        .ent_a_i    (ent_a),
        .we_b_i     (b_push),
        .idx_b_i    (idx_b),
        .ent_b_i    (ent_b),
        .head_i     (head_q),
        .count_i    (count_q),
        .head_ent_o (head_ent),
        .out_vld_i  (RegWrite),
        .out_ent_i  (out_ent),
        .lk_reg_i   (lk_reg),
        .lk_hit_o   (lk_hit),
        .lk_data_o  (lk_data)
    );

    assign LookupHit1  = lk_hit[0];
    assign LookupData1 = lk_data[0];
    assign LookupHit2  = lk_hit[1];
    assign LookupData2 = lk_data[1];
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Queue-level reference model of the write scheduler driven by directed and random write-backs.
module tb_regfile_write_scheduler;
    localparam int DEPTH = 4;

    logic        Clk = 1'b0, Reset = 1'b0;
    logic        AValid = 0, BValid = 0;
    logic [4:0]  AReg = 0, BReg = 0, LookupReg1 = 0, LookupReg2 = 0;
    logic [31:0] AData = 0, BData = 0;
    logic        BReady, Stall, LookupHit1, LookupHit2, RegWrite, OverflowErr;
    logic [31:0] LookupData1, LookupData2, WriteData;
    logic [4:0]  WriteRegister;

    regfile_write_scheduler #(.DEPTH(DEPTH), .WIDTH(32), .AWIDTH(5)) dut (
        .Clk(Clk), .Reset(Reset),
        .AValid(AValid), .AReg(AReg), .AData(AData),
        .BValid(BValid), .BReg(BReg), .BData(BData), .BReady(BReady),
        .Stall(Stall),
        .LookupReg1(LookupReg1), .LookupHit1(LookupHit1), .LookupData1(LookupData1),
        .LookupReg2(LookupReg2), .LookupHit2(LookupHit2), .LookupData2(LookupData2),
        .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
        .OverflowErr(OverflowErr)
    );

    always #5 Clk = ~Clk;

    typedef struct { logic [4:0] r; logic [31:0] d; } ent_t;

    // Reference state: pending writes in acceptance order plus the register-file port.
    ent_t        q[$];
    ent_t        wlog[$];
    logic        m_rw = 0, m_ovf = 0;
    logic [4:0]  m_wr = 0;
    logic [31:0] m_wd = 0;
    logic [31:0] rf [32];
    bit          b_acc;
    int          n_chk = 0, n_err = 0;

    // Register file model: captures on the falling edge.
    always @(negedge Clk) if (RegWrite) rf[WriteRegister] <= WriteData;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void lookup(input logic [4:0] r, output logic h, output logic [31:0] d);
        h = 0; d = 0;
        if (r == 0) return;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].r == r) begin h = 1; d = q[i].d; return; end
        if (m_rw && m_wr == r) begin h = 1; d = m_wd; end
    endfunction

    // One clock: check combinational outputs, advance the model at posedge, check registered outputs.
    task automatic step();
        bit st, aacc, brdy;
        logic h; logic [31:0] d;
        ent_t e;
        #1;
        st   = q.size() >= DEPTH - 1;
        aacc = AValid && !st && AReg != 0;
        brdy = BValid && (BReg == 0 || (q.size() + int'(aacc)) < DEPTH);
        chk("stall", Stall, st);
        chk("bready", BReady, brdy);
        lookup(LookupReg1, h, d); chk("hit1", LookupHit1, h); chk("data1", LookupData1, d);
        lookup(LookupReg2, h, d); chk("hit2", LookupHit2, h); chk("data2", LookupData2, d);
        @(posedge Clk);
        if (Reset) begin
            q.delete(); m_rw = 0; m_wr = 0; m_wd = 0; m_ovf = 0;
        end else begin
            if (AValid && st) m_ovf = 1;
            if (q.size() > 0) begin e = q.pop_front(); m_rw = 1; m_wr = e.r; m_wd = e.d; end
            else m_rw = 0;
            if (aacc) q.push_back('{AReg, AData});
            if (brdy && BReg != 0) q.push_back('{BReg, BData});
        end
        b_acc = brdy;
        @(negedge Clk);
        chk("regwrite", RegWrite, m_rw);
        chk("wreg", WriteRegister, m_wr);
        chk("wdata", WriteData, m_wd);
        chk("ovf", OverflowErr, m_ovf);
        if (RegWrite) wlog.push_back('{WriteRegister, WriteData});
    endtask

    task automatic idle(input int n);
        AValid = 0; BValid = 0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        Reset = 1; AValid = 0; BValid = 0;
        step();
        Reset = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 0;
        @(negedge Clk);
        do_reset();
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_stall", Stall, 0);

        // Single A write to $5.
        AValid = 1; AReg = 5; AData = 32'hDEADBEEF; LookupReg1 = 5;
        step();
        AValid = 0;
        step();
        chk("single_wreg", WriteRegister, 5);
        chk("single_wdata", WriteData, 32'hDEADBEEF);
        idle(1);
        chk("rf5", rf[5], 32'hDEADBEEF);

        // Same-cycle A and B to $3: B is younger.
        wlog.delete();
        AValid = 1; AReg = 3; AData = 32'h11; BValid = 1; BReg = 3; BData = 32'h22; LookupReg1 = 3;
        step();
        AValid = 0; BValid = 0;
        #1 chk("ab_lookup", LookupData1, 32'h22);
        idle(4);
        chk("ab_order_n", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("ab_first", wlog[0].d, 32'h11);
            chk("ab_second", wlog[1].d, 32'h22);
        end
        chk("ab_drained_hit", LookupHit1, 0);

        // Register zero from both sources.
        wlog.delete();
        AValid = 1; AReg = 0; AData = 32'hFFFF; BValid = 1; BReg = 0; BData = 32'hFFFF; LookupReg1 = 0;
        #1 chk("zero_bready", BReady, 1);
        step();
        idle(3);
        chk("zero_no_write", wlog.size(), 0);

        // Reset mid-drain with three entries queued.
        AValid = 1; AReg = 7; AData = 1; BValid = 1; BReg = 8; BData = 2;
        step();
        BValid = 0; AReg = 9; AData = 3;
        step();
        AValid = 0;
        do_reset();
        wlog.delete();
        chk("mid_rst_stall", Stall, 0);
        chk("mid_rst_wdata", WriteData, 0);
        idle(4);
        chk("mid_rst_no_write", wlog.size(), 0);

        // Backpressure: both sources every cycle, B held until accepted.
        BValid = 1; BReg = 1; BData = 32'h100;
        for (int i = 0; i < 8; i++) begin
            AValid = 1; AReg = 5'(10 + i); AData = 32'(i);
            step();
            if (b_acc) begin BReg = 5'(1 + (i % 6)); BData = 32'h100 + 32'(i); end
        end
        #1 chk("bp_stall", Stall, 1);
        idle(6);
        chk("bp_ovf_sticky", OverflowErr, 1);
        do_reset();
        chk("bp_ovf_cleared", OverflowErr, 0);

        // Wrap-around: ten alternating A/B writes.
        wlog.delete();
        for (int i = 1; i <= 10; i++) begin
            AValid = (i % 2 == 1); BValid = (i % 2 == 0);
            AReg = 5'(i); BReg = 5'(i); AData = 32'(i * 'h100); BData = 32'(i * 'h100);
            step();
        end
        idle(6);
        chk("wrap_n", wlog.size(), 10);
        for (int i = 0; i < wlog.size() && i < 10; i++) begin
            chk("wrap_reg", wlog[i].r, 5'(i + 1));
            chk("wrap_data", wlog[i].d, 32'((i + 1) * 'h100));
        end

        // Random traffic against the queue model.
        BValid = 0; b_acc = 1;
        for (int c = 0; c < 400; c++) begin
            if (!BValid || b_acc) begin
                BValid = ($urandom_range(0, 2) != 0);
                BReg = 5'($urandom_range(0, 7)); BData = $urandom;
            end
            AValid = ($urandom_range(0, 9) < 4);
            AReg = 5'($urandom_range(0, 7)); AData = $urandom;
            LookupReg1 = 5'($urandom_range(0, 7)); LookupReg2 = 5'($urandom_range(0, 7));
            Reset = ($urandom_range(0, 99) == 0);
            step();
            Reset = 0;
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
